fetch_stage2: RTL and testbench

Second fetch stage. Registers the 4-instruction bundle produced by FetchStage1, predecodes each slot, and resolves direct-control targets one cycle after fetch. It generates the ID-stage redirect (`flagRecoverID`, `targetAddrID`, `flagCallID`, `callPCID`, `flagRtrID`) that feeds back into FetchStage1's next-PC and RAS logic, and forwards a slot-masked bundle to decode.

---
 rtl/fetch_stage2.sv | 252 +++++++++++++++++++++++++
 tb/tb_fetch_stage2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage2.sv
// fetch_stage2
//   Second fetch stage. Registers the 4-slot bundle from FetchStage1,
//   predecodes every slot, and resolves direct-control targets one cycle
//   after fetch. When this stage's view of the next PC disagrees with the
//   one FetchStage1 predicted, it raises an ID redirect, plus RAS push and
//   restore hints. It also forwards the bundle to decode with slots past the
//   redirect slot masked off.
//
// Ports
//   clk, reset            : clock, async active-low reset
//   stall_i, flush_i      : downstream stall (hold), EX flush (kill)
//   fs1Ready_i, pc_i,
//   instructionBundle_i,
//   btbHit_i, prediction_i,
//   targetAddr{0..3}_i    : FetchStage1 bundle and its per-slot predictions
//   flagRecoverID_o,
//   targetAddrID_o        : redirect FetchStage1 to the expected next PC
//   flagCallID_o,
//   callPCID_o            : call missed in BTB, push return address
//   flagRtrID_o           : return missed in BTB, restore RAS checkpoint
//   fs2Valid_o, pc_o,
//   instructionBundle_o,
//   slotMask_o, nextPC_o  : registered bundle to decode

// Per-slot predecode: classifies one instruction and produces its expected
// successor plus the two "taken" views (actual and FS1-predicted).
module fetch_stage2_slot #(
    parameter int SIZE_PC = 32,
    parameter int INST_W  = 64
) (
    input  logic [SIZE_PC-1:0] i_pc,
    input  logic [INST_W-1:0]  i_instr,
    input  logic               i_btb_hit,
    input  logic               i_pred,
    input  logic [SIZE_PC-1:0] i_fs1_tgt,
    output logic               o_actual,
    output logic               o_fs1_take,
    output logic               o_call,
    output logic               o_ret,
    output logic [SIZE_PC-1:0] o_exp_tgt
);
    localparam logic [7:0] OP_J    = 8'h01;
    localparam logic [7:0] OP_JAL  = 8'h02;
    localparam logic [7:0] OP_JR   = 8'h03;
    localparam logic [7:0] OP_JALR = 8'h04;
    localparam logic [7:0] OP_RET  = 8'h05;

    logic [7:0]         w_op;
    logic               w_jmp;
    logic               w_ind;
    logic               w_br;
    logic [SIZE_PC-1:0] w_jmp_tgt;
    logic [SIZE_PC-1:0] w_br_tgt;
    logic               w_unused;

    assign w_op  = i_instr[INST_W-1 -: 8];
    assign w_jmp = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_ind = (w_op == OP_JR) || (w_op == OP_JALR);
    assign w_br  = (w_op[7:3] == 5'b00010);          // 0x10..0x17
    assign o_ret = (w_op == OP_RET);
    assign o_call = (w_op == OP_JAL) || (w_op == OP_JALR);

    assign w_jmp_tgt = {i_pc[SIZE_PC-1:29], i_instr[25:0], 3'b000};
    assign w_br_tgt  = i_pc + SIZE_PC'(8)
                     + {{(SIZE_PC-19){i_instr[15]}}, i_instr[15:0], 3'b000};

    // Direct jumps and RET always redirect; indirect jumps only when the BTB
    // supplied a target; branches only when predicted taken.
    assign o_actual = w_jmp || o_ret || (w_ind && i_btb_hit)
                   || (w_br && i_btb_hit && i_pred);

    // FS1 follows any BTB hit that is not a not-taken branch, including
    // aliased hits on non-control slots.
    assign o_fs1_take = i_btb_hit && (i_pred || !w_br);

    // RET/JR/JALR trust the FS1 (RAS-substituted) target.
    assign o_exp_tgt = w_jmp ? w_jmp_tgt :
                       w_br  ? w_br_tgt  : i_fs1_tgt;

    assign w_unused = ^i_instr[INST_W-9:26];
endmodule

module fetch_stage2 #(
    parameter int SIZE_PC = 32,
    parameter int INST_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  fs1Ready_i,
    input  logic [SIZE_PC-1:0]    pc_i,
    input  logic [4*INST_W-1:0]   instructionBundle_i,
    input  logic [3:0]            btbHit_i,
    input  logic [3:0]            prediction_i,
    input  logic [SIZE_PC-1:0]    targetAddr0_i,
    input  logic [SIZE_PC-1:0]    targetAddr1_i,
    input  logic [SIZE_PC-1:0]    targetAddr2_i,
    input  logic [SIZE_PC-1:0]    targetAddr3_i,
    output logic                  flagRecoverID_o,
    output logic [SIZE_PC-1:0]    targetAddrID_o,
    output logic                  flagCallID_o,
    output logic [SIZE_PC-1:0]    callPCID_o,
    output logic                  flagRtrID_o,
    output logic                  fs2Valid_o,
    output logic [SIZE_PC-1:0]    pc_o,
    output logic [4*INST_W-1:0]   instructionBundle_o,
    output logic [3:0]            slotMask_o,
    output logic [SIZE_PC-1:0]    nextPC_o
);
    localparam int NUM_SLOTS = 4;
    localparam logic [SIZE_PC-1:0] BUNDLE_BYTES = SIZE_PC'(8 * NUM_SLOTS);

    typedef struct packed {
        logic [SIZE_PC-1:0]                  pc;
        logic [NUM_SLOTS-1:0][INST_W-1:0]    bundle;
        logic [NUM_SLOTS-1:0]                btb_hit;
        logic [NUM_SLOTS-1:0]                pred;
        logic [NUM_SLOTS-1:0][SIZE_PC-1:0]   tgt;
    } stage_t;

    logic   r_valid;
    stage_t r_stage;
    stage_t w_stage_in;

    logic [NUM_SLOTS-1:0]              w_actual;
    logic [NUM_SLOTS-1:0]              w_fs1_take;
    logic [NUM_SLOTS-1:0]              w_call;
    logic [NUM_SLOTS-1:0]              w_ret;
    logic [NUM_SLOTS-1:0][SIZE_PC-1:0] w_exp_tgt;
    logic [NUM_SLOTS-1:0][SIZE_PC-1:0] w_slot_pc;

    logic               w_s_found;
    logic [1:0]         w_s;
    logic               w_f_found;
    logic [1:0]         w_f;
    logic [SIZE_PC-1:0] w_seq_pc;
    logic [SIZE_PC-1:0] w_exp_pc;
    logic [SIZE_PC-1:0] w_fs1_pc;
    logic               w_redirect;
    logic               w_gate;

    assign w_stage_in.pc      = pc_i;
    assign w_stage_in.bundle  = instructionBundle_i;
    assign w_stage_in.btb_hit = btbHit_i;
    assign w_stage_in.pred    = prediction_i;
    assign w_stage_in.tgt     = {targetAddr3_i, targetAddr2_i,
                                 targetAddr1_i, targetAddr0_i};

    // Flush kills valid even while stalled. On a load, the FS1 bundle that
    // arrives alongside our own redirect is wrong-path and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_stage <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_valid <= fs1Ready_i && !w_redirect;
            r_stage <= w_stage_in;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            assign w_slot_pc[k] = r_stage.pc + SIZE_PC'(8 * k);
            fetch_stage2_slot #(
                .SIZE_PC (SIZE_PC),
                .INST_W  (INST_W)
            ) u_slot (
                .i_pc       (w_slot_pc[k]),
                .i_instr    (r_stage.bundle[k]),
                .i_btb_hit  (r_stage.btb_hit[k]),
                .i_pred     (r_stage.pred[k]),
                .i_fs1_tgt  (r_stage.tgt[k]),
                .o_actual   (w_actual[k]),
                .o_fs1_take (w_fs1_take[k]),
                .o_call     (w_call[k]),
                .o_ret      (w_ret[k]),
                .o_exp_tgt  (w_exp_tgt[k])
            );
        end
    endgenerate

    // Lowest-slot priority encoders for the actual (s) and FS1 (f) redirect
    // slots; scanning downward lets the lowest hit win.
    always_comb begin
        w_s_found = 1'b0;
        w_s       = 2'd0;
        w_f_found = 1'b0;
        w_f       = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_actual[i]) begin
                w_s_found = 1'b1;
                w_s       = 2'(i);
            end
            if (w_fs1_take[i]) begin
                w_f_found = 1'b1;
                w_f       = 2'(i);
            end
        end
    end

    assign w_seq_pc = r_stage.pc + BUNDLE_BYTES;
    assign w_exp_pc = w_s_found ? w_exp_tgt[w_s]      : w_seq_pc;
    assign w_fs1_pc = w_f_found ? r_stage.tgt[w_f]    : w_seq_pc;

    // Redirect if target or the ending slot differ; a matching target from a
    // different slot still means FS1 masked the bundle wrongly.
    assign w_redirect = r_valid
                     && ((w_exp_pc != w_fs1_pc)
                      || (w_s_found != w_f_found)
                      || (w_s_found && (w_s != w_f)));

    // While stalled the redirect is withheld and re-evaluated from the held
    // register on release, so FS1 sees it exactly once. Flush overrides.
    assign w_gate = !stall_i && !flush_i;

    assign flagRecoverID_o = w_redirect && w_gate;
    assign flagCallID_o    = flagRecoverID_o && w_s_found
                          && w_call[w_s] && !r_stage.btb_hit[w_s];
    assign flagRtrID_o     = flagRecoverID_o && w_s_found
                          && w_ret[w_s] && !r_stage.btb_hit[w_s];

    // Address outputs are zeroed when the register is empty so an idle
    // stage drives all-zero outputs.
    assign targetAddrID_o = r_valid ? w_exp_pc : '0;
    assign nextPC_o       = r_valid ? w_exp_pc : '0;
    assign callPCID_o     = (r_valid && w_s_found)
                          ? w_slot_pc[w_s] + SIZE_PC'(8) : '0;

    always_comb begin
        slotMask_o = 4'b0000;
        if (r_valid) begin
            if (!w_s_found) begin
                slotMask_o = 4'b1111;
            end else begin
                case (w_s)
                    2'd0:    slotMask_o = 4'b0001;
                    2'd1:    slotMask_o = 4'b0011;
                    2'd2:    slotMask_o = 4'b0111;
                    default: slotMask_o = 4'b1111;
                endcase
            end
        end
    end

    assign fs2Valid_o          = r_valid;
    assign pc_o                = r_stage.pc;
    assign instructionBundle_o = r_stage.bundle;
endmodule

// File: tb/tb_fetch_stage2.sv
// Directed bench for fetch_stage2: hand-computed redirect / mask / RAS hint
// vectors, stall hold-and-release, flush priority, async reset mid-stall.
module tb_fetch_stage2;
    localparam int SIZE_PC = 32;
    localparam int INST_W  = 64;

    logic                clk;
    logic                reset;
    logic                stall_i;
    logic                flush_i;
    logic                fs1Ready_i;
    logic [SIZE_PC-1:0]  pc_i;
    logic [4*INST_W-1:0] instructionBundle_i;
    logic [3:0]          btbHit_i;
    logic [3:0]          prediction_i;
    logic [SIZE_PC-1:0]  targetAddr0_i, targetAddr1_i, targetAddr2_i, targetAddr3_i;
    logic                flagRecoverID_o;
    logic [SIZE_PC-1:0]  targetAddrID_o;
    logic                flagCallID_o;
    logic [SIZE_PC-1:0]  callPCID_o;
    logic                flagRtrID_o;
    logic                fs2Valid_o;
    logic [SIZE_PC-1:0]  pc_o;
    logic [4*INST_W-1:0] instructionBundle_o;
    logic [3:0]          slotMask_o;
    logic [SIZE_PC-1:0]  nextPC_o;

    int n_chk = 0;
    int n_err = 0;

    fetch_stage2 #(.SIZE_PC(SIZE_PC), .INST_W(INST_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .fs1Ready_i          (fs1Ready_i),
        .pc_i                (pc_i),
        .instructionBundle_i (instructionBundle_i),
        .btbHit_i            (btbHit_i),
        .prediction_i        (prediction_i),
        .targetAddr0_i       (targetAddr0_i),
        .targetAddr1_i       (targetAddr1_i),
        .targetAddr2_i       (targetAddr2_i),
        .targetAddr3_i       (targetAddr3_i),
        .flagRecoverID_o     (flagRecoverID_o),
        .targetAddrID_o      (targetAddrID_o),
        .flagCallID_o        (flagCallID_o),
        .callPCID_o          (callPCID_o),
        .flagRtrID_o         (flagRtrID_o),
        .fs2Valid_o          (fs2Valid_o),
        .pc_o                (pc_o),
        .instructionBundle_o (instructionBundle_o),
        .slotMask_o          (slotMask_o),
        .nextPC_o            (nextPC_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [25:0] fld);
        return {op, 30'd0, fld};
    endfunction

    localparam logic [63:0] NOP = 64'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] pc,
                         input logic [63:0] i0, input logic [63:0] i1,
                         input logic [63:0] i2, input logic [63:0] i3,
                         input logic [3:0] btb, input logic [3:0] pred,
                         input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] t2, input logic [31:0] t3);
        fs1Ready_i          = rdy;
        pc_i                = pc;
        instructionBundle_i = {i3, i2, i1, i0};
        btbHit_i            = btb;
        prediction_i        = pred;
        targetAddr0_i       = t0;
        targetAddr1_i       = t1;
        targetAddr2_i       = t2;
        targetAddr3_i       = t3;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, NOP, NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, NOP, NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        #2;
        chk("rst_valid",  fs2Valid_o, 0);
        chk("rst_recov",  flagRecoverID_o, 0);
        chk("rst_tgt",    targetAddrID_o, 0);
        chk("rst_callpc", callPCID_o, 0);
        chk("rst_mask",   slotMask_o, 0);
        chk("rst_next",   nextPC_o, 0);
        tick();
        reset = 1'b1;

        // J at slot 1, target field 0x200 -> 0x1000; FS1 predicted 0x1020.
        drive(1'b1, 32'h1000, NOP, mk(8'h01, 26'h200), NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        chk("j_valid", fs2Valid_o, 1);
        chk("j_pc",    pc_o, 32'h1000);
        chk("j_recov", flagRecoverID_o, 1);
        chk("j_tgt",   targetAddrID_o, 32'h1000);
        chk("j_next",  nextPC_o, 32'h1000);
        chk("j_mask",  slotMask_o, 4'b0011);
        chk("j_call",  flagCallID_o, 0);
        // Bundle fetched alongside the redirect is wrong-path.
        drive(1'b1, 32'h1020, NOP, NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        chk("j_drop_valid", fs2Valid_o, 0);
        chk("j_drop_recov", flagRecoverID_o, 0);
        chk("j_drop_mask",  slotMask_o, 0);

        // Branch slot 2 @0x2010, imm -1 word*... 0x2018 - 16 = 0x2008; FS1 agrees.
        drive(1'b1, 32'h2000, NOP, NOP, mk(8'h10, 26'hFFFE), NOP, 4'b0100, 4'b0100, 0, 0, 32'h2008, 0);
        tick();
        chk("br_ok_valid", fs2Valid_o, 1);
        chk("br_ok_recov", flagRecoverID_o, 0);
        chk("br_ok_next",  nextPC_o, 32'h2008);
        chk("br_ok_mask",  slotMask_o, 4'b0111);

        // Same branch, FS1 target wrong.
        drive(1'b1, 32'h2000, NOP, NOP, mk(8'h10, 26'hFFFE), NOP, 4'b0100, 4'b0100, 0, 0, 32'h3000, 0);
        tick();
        chk("br_bad_valid", fs2Valid_o, 1);
        chk("br_bad_recov", flagRecoverID_o, 1);
        chk("br_bad_tgt",   targetAddrID_o, 32'h2008);
        bubble();

        // JAL slot 0 @0x4000, field 0x900 -> 0x4800, BTB miss.
        drive(1'b1, 32'h4000, mk(8'h02, 26'h900), NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        chk("jal_recov",  flagRecoverID_o, 1);
        chk("jal_tgt",    targetAddrID_o, 32'h4800);
        chk("jal_call",   flagCallID_o, 1);
        chk("jal_callpc", callPCID_o, 32'h4008);
        chk("jal_rtr",    flagRtrID_o, 0);
        chk("jal_mask",   slotMask_o, 4'b0001);
        bubble();

        // RET slot 3 @0x5000, BTB miss, RAS target 0x7770.
        drive(1'b1, 32'h5000, NOP, NOP, NOP, mk(8'h05, 26'h0), 4'h0, 4'h0, 0, 0, 0, 32'h7770);
        tick();
        chk("ret_recov", flagRecoverID_o, 1);
        chk("ret_rtr",   flagRtrID_o, 1);
        chk("ret_call",  flagCallID_o, 0);
        chk("ret_tgt",   targetAddrID_o, 32'h7770);
        chk("ret_mask",  slotMask_o, 4'b1111);
        bubble();

        // Aliased BTB hit on a non-control slot: corrected to sequential PC.
        drive(1'b1, 32'h6000, NOP, NOP, NOP, NOP, 4'b0010, 4'b0000, 0, 32'h9000, 0, 0);
        tick();
        chk("alias_recov", flagRecoverID_o, 1);
        chk("alias_tgt",   targetAddrID_o, 32'h6020);
        chk("alias_mask",  slotMask_o, 4'b1111);
        bubble();

        // Flush in the redirect cycle wins.
        drive(1'b1, 32'h1000, NOP, mk(8'h01, 26'h200), NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        flush_i = 1'b1;
        #1;
        chk("flush_recov", flagRecoverID_o, 0);
        tick();
        chk("flush_valid", fs2Valid_o, 0);
        flush_i = 1'b0;

        // Redirect held under a 3-cycle stall, released exactly once.
        drive(1'b1, 32'h1000, NOP, mk(8'h01, 26'h200), NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        stall_i = 1'b1;
        drive(1'b1, 32'h8000, NOP, NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        #1;
        chk("stall_recov0", flagRecoverID_o, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("stall_recov", flagRecoverID_o, 0);
            chk("stall_pc",    pc_o, 32'h1000);
            chk("stall_valid", fs2Valid_o, 1);
        end
        stall_i = 1'b0;
        #1;
        chk("release_recov", flagRecoverID_o, 1);
        chk("release_tgt",   targetAddrID_o, 32'h1000);
        tick();
        chk("release_once",  flagRecoverID_o, 0);
        chk("release_drop",  fs2Valid_o, 0);

        // Async reset mid-stall.
        drive(1'b1, 32'hA000, NOP, NOP, NOP, NOP, 4'h0, 4'h0, 0, 0, 0, 0);
        tick();
        chk("pre_rst_valid", fs2Valid_o, 1);
        stall_i = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", fs2Valid_o, 0);
        chk("arst_pc",    pc_o, 0);
        #1;
        reset = 1'b1;
        tick();
        chk("arst_stall_valid", fs2Valid_o, 0);
        stall_i = 1'b0;
        tick();
        chk("arst_load_valid", fs2Valid_o, 1);
        chk("arst_load_pc",    pc_o, 32'hA000);
        chk("arst_load_next",  nextPC_o, 32'hA020);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
